// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential restoring
// divider (state encoding, default width, iteration-counter width helper).
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   // Bits needed to hold the iteration count WIDTH-1 down to 0.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a requester (master) and the
// divider (slave). Operands travel with start; results come back with done.
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_divider_step.sv
// divider_step: one combinational restoring-division iteration. Shifts the
// next dividend bit into the partial remainder, trial-subtracts the divisor
// and keeps the difference only when it does not go negative.
module divider_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);

   // The trial subtraction is one bit wider than strictly needed so the full
   // partial remainder takes part; its top bit is always zero between
   // iterations, so the sign test is the same as a WIDTH+1 bit subtraction.
   logic [WIDTH+1:0] shifted_s;
   logic [WIDTH+1:0] diff_s;

   // Trial subtract and restore-or-keep decision.
   always_comb begin
      shifted_s = {r, q[WIDTH-1]};
      diff_s    = shifted_s - {2'b00, divisor};
      r_next    = shifted_s[WIDTH:0];
      q_next    = {q[WIDTH-2:0], 1'b0};
      if (diff_s[WIDTH+1] == 1'b0) begin
         r_next = diff_s[WIDTH:0];
         q_next = {q[WIDTH-2:0], 1'b1};
      end else begin
         r_next = shifted_s[WIDTH:0];
         q_next = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per
// clock, results presented with a one-cycle done pulse.
// Optional feature: define SEQ_DIVIDER_DBZ_CHECK_EN to short-circuit a zero
// divisor straight to DONE (latency 1) and raise div_by_zero with done.
// Without it a zero divisor iterates normally (quotient all ones,
// remainder = dividend) and div_by_zero stays low.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_r;
   logic [WIDTH:0]   r_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] divisor_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic [WIDTH:0]   r_next_s;
   logic [WIDTH-1:0] q_next_s;
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
   logic             dbz_r;
`endif

   divider_step #(.WIDTH(WIDTH)) u_step (
      .r       (r_r),
      .q       (q_r),
      .divisor (divisor_r),
      .r_next  (r_next_s),
      .q_next  (q_next_s)
   );

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         r_r         <= {(WIDTH+1){1'b0}};
         q_r         <= {WIDTH{1'b0}};
         divisor_r   <= {WIDTH{1'b0}};
         cnt_r       <= {CW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
         dbz_r       <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  divisor_r <= bus.divisor;
                  r_r       <= {(WIDTH+1){1'b0}};
                  q_r       <= bus.dividend;
                  cnt_r     <= CW'(WIDTH - 1);
                  busy_r    <= 1'b1;
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
                  if (bus.divisor == {WIDTH{1'b0}}) begin
                     state_r     <= DONE;
                     done_r      <= 1'b1;
                     quotient_r  <= {WIDTH{1'b1}};
                     remainder_r <= bus.dividend;
                     dbz_r       <= 1'b1;
                  end else begin
                     state_r     <= RUN;
                  end
`else
                  state_r   <= RUN;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               r_r <= r_next_s;
               q_r <= q_next_s;
               if (cnt_r == {CW{1'b0}}) begin
                  state_r     <= DONE;
                  done_r      <= 1'b1;
                  quotient_r  <= q_next_s;
                  remainder_r <= r_next_s[WIDTH-1:0];
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
                  dbz_r       <= 1'b0;
`endif
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
   assign bus.div_by_zero = dbz_r;
`else
   assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider at WIDTH=4 and WIDTH=8.
// Expected results come from plain integer division in the bench.
module tb_seq_divider;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
   localparam bit DBZ_EN = 1'b1;
`else
   localparam bit DBZ_EN = 1'b0;
`endif

   seq_divider_if #(.WIDTH(4)) if4 ();
   seq_divider_if #(.WIDTH(8)) if8 ();

   seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: quotient/remainder by integer arithmetic.
   function automatic void model(input int a, input int d, input int w,
                                 output int q, output int r, output bit z,
                                 output int cyc);
      if (d == 0) begin
         q = (1 << w) - 1;
         r = a;
         z = DBZ_EN;
         cyc = DBZ_EN ? 1 : w + 1;
      end else begin
         q = a / d;
         r = a % d;
         z = 1'b0;
         cyc = w + 1;
      end
   endfunction

   // One WIDTH=4 transaction; called at posedge+1, returns one cycle after done.
   task automatic run4(input int a, input int d, output int cyc,
                       output int q, output int r, output bit z,
                       output bit busy1, output bit done_after, output bit busy_after);
      if4.start    = 1'b1;
      if4.dividend = 4'(a);
      if4.divisor  = 4'(d);
      @(posedge clk); #1;
      if4.start = 1'b0;
      busy1 = if4.busy;
      cyc = -1;
      for (int k = 1; k <= 20 && cyc < 0; k++) begin
         if (if4.done === 1'b1) cyc = k;
         else begin @(posedge clk); #1; end
      end
      q = int'(if4.quotient);
      r = int'(if4.remainder);
      z = if4.div_by_zero;
      @(posedge clk); #1;
      done_after = if4.done;
      busy_after = if4.busy;
   endtask

   // One WIDTH=8 transaction, same timing contract as run4.
   task automatic run8(input int a, input int d, output int cyc,
                       output int q, output int r, output bit z,
                       output bit done_after, output bit busy_after);
      if8.start    = 1'b1;
      if8.dividend = 8'(a);
      if8.divisor  = 8'(d);
      @(posedge clk); #1;
      if8.start = 1'b0;
      cyc = -1;
      for (int k = 1; k <= 30 && cyc < 0; k++) begin
         if (if8.done === 1'b1) cyc = k;
         else begin @(posedge clk); #1; end
      end
      q = int'(if8.quotient);
      r = int'(if8.remainder);
      z = if8.div_by_zero;
      @(posedge clk); #1;
      done_after = if8.done;
      busy_after = if8.busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.quotient !== 4'd0 ||
          if4.remainder !== 4'd0 || if4.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset4: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                  if4.busy, if4.done, if4.quotient, if4.remainder, if4.div_by_zero);
      end
      checks++;
      if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.quotient !== 8'd0 ||
          if8.remainder !== 8'd0 || if8.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset8: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                  if8.busy, if8.done, if8.quotient, if8.remainder, if8.div_by_zero);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Full check of one WIDTH=4 division against the model.
   task automatic check4(input int a, input int d, input string tag);
      int cyc, q, r, eq, er, ecyc;
      bit z, ez, b1, da, ba;
      model(a, d, 4, eq, er, ez, ecyc);
      run4(a, d, cyc, q, r, z, b1, da, ba);
      checks++;
      if (cyc != ecyc) begin
         errors++;
         $display("FAIL %s latency %0d/%0d: done at T+%0d, required T+%0d", tag, a, d, cyc, ecyc);
      end
      checks++;
      if (q != eq || r != er || z != ez) begin
         errors++;
         $display("FAIL %s result %0d/%0d: q=%0d r=%0d z=%0d, required q=%0d r=%0d z=%0d",
                  tag, a, d, q, r, z, eq, er, ez);
      end
      checks++;
      if (b1 !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin
         errors++;
         $display("FAIL %s handshake %0d/%0d: busy@T+1=%b done_after=%b busy_after=%b, required 1 0 0",
                  tag, a, d, b1, da, ba);
      end
   endtask

   task automatic test_basic();
      check4(13, 4, "basic");
      check4(15, 1, "basic");
      check4(3, 7, "basic");
      check4(0, 5, "basic");
      check4(15, 15, "basic");
      for (int i = 0; i < 20; i++)
         check4(int'($urandom_range(15, 0)), int'($urandom_range(15, 1)), "rand4");
   endtask

   task automatic test_div_zero();
      check4(9, 0, "dbz");
      check4(0, 0, "dbz");
      check4(15, 0, "dbz");
   endtask

   task automatic test_ignore_start();
      int cyc;
      check4(6, 3, "pre_ignore");
      if4.start = 1'b1; if4.dividend = 4'd13; if4.divisor = 4'd4;
      @(posedge clk); #1;                     // edge T accepted
      if4.start = 1'b0;
      @(posedge clk); #1;                     // after T+1
      if4.start = 1'b1; if4.dividend = 4'd6; if4.divisor = 4'd2;
      @(posedge clk); #1;                     // edge T+2 samples the stray start
      if4.start = 1'b0;
      checks++;
      if (if4.quotient !== 4'd2 || if4.remainder !== 4'd0) begin
         errors++;
         $display("FAIL held_result: q=%0d r=%0d during run, required 2 0",
                  if4.quotient, if4.remainder);
      end
      cyc = -1;
      for (int k = 3; k <= 20 && cyc < 0; k++) begin
         if (if4.done === 1'b1) cyc = k;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (cyc != 5 || if4.quotient !== 4'd3 || if4.remainder !== 4'd1) begin
         errors++;
         $display("FAIL ignore_start: done at T+%0d q=%0d r=%0d, required T+5 q=3 r=1",
                  cyc, if4.quotient, if4.remainder);
      end
      @(posedge clk); #1;
      checks++;
      if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_queue: done=%b busy=%b after result, required 0 0",
                  if4.done, if4.busy);
      end
      check4(6, 2, "reissue");
   endtask

   task automatic test_reset_mid();
      bit seen;
      if4.start = 1'b1; if4.dividend = 4'd13; if4.divisor = 4'd4;
      @(posedge clk); #1;
      if4.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (if4.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: busy=%b before reset, required 1", if4.busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;                     // edge T+3
      checks++;
      if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.quotient !== 4'd0 ||
          if4.remainder !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b done=%b q=%0d r=%0d, required 0 0 0 0",
                  if4.busy, if4.done, if4.quotient, if4.remainder);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (if4.done === 1'b1 || if4.busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_no_done: done/busy seen after abort=%b, required 0", seen);
      end
      check4(7, 2, "post_reset");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         check4(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), "b2b");
   endtask

   task automatic test_sweep8();
      int cyc, q, r, a, d;
      bit z, da, ba;
      int corner_a [6] = '{255, 255, 0, 1, 128, 200};
      int corner_d [6] = '{1, 255, 1, 255, 3, 201};
      for (int i = 0; i < 1206; i++) begin
         if (i < 6) begin
            a = corner_a[i];
            d = corner_d[i];
         end else begin
            a = int'($urandom_range(255, 0));
            d = int'($urandom_range(255, 1));
         end
         run8(a, d, cyc, q, r, z, da, ba);
         checks++;
         if (q * d + r != a || r >= d || q != a / d || z != 1'b0) begin
            errors++;
            $display("FAIL sweep8 %0d/%0d: q=%0d r=%0d z=%0d, required q=%0d r=%0d z=0",
                     a, d, q, r, z, a / d, a % d);
         end
         checks++;
         if (cyc != 9 || da !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL sweep8_done %0d/%0d: done at T+%0d done_after=%b busy_after=%b, required T+9 0 0",
                     a, d, cyc, da, ba);
         end
      end
   endtask

   // Test sequence.
   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      if4.start = 1'b0; if4.dividend = 4'd0; if4.divisor = 4'd0;
      if8.start = 1'b0; if8.dividend = 8'd0; if8.divisor = 8'd0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_sweep8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
